// File: rtl/dmtd_stream_if.sv
// Result stream of the DMTD phase meter: one channel/phase/miss entry per valid/ready beat.
`timescale 1ns/1ps
interface dmtd_stream_if #(
   parameter int unsigned CH_W  = 2,
   parameter int unsigned CNT_W = 16
);
   logic             valid;
   logic             ready;
   logic [CH_W-1:0]  ch;
   logic [CNT_W-1:0] phase;
   logic             miss;

   modport master (output valid, ch, phase, miss, input ready);
   modport slave  (input valid, ch, phase, miss, output ready);
endinterface

// File: rtl/dmtd_multi_phase_meter.sv
// Multi-channel DMTD phase meter: deglitched beat edges time-tagged against channel 0.
// Optional `DMTD_REF_PERIOD_EN adds a channel-0 reference-period entry ahead of each drain.
`timescale 1ns/1ps
module dmtd_multi_phase_meter #(
   parameter int unsigned N_CH         = 3,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DLY_W        = 7,
   parameter int unsigned DEGLITCH_LEN = 4,
   parameter int unsigned TIMEOUT      = 1000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_en,
   input  logic [N_CH-1:0]     i_async_clk,
   input  logic                i_delay_sign,
   input  logic [DLY_W-1:0]    i_delay,
   dmtd_stream_if.master       o_stream,
   output logic [N_CH-1:0]     o_beat_out,
   output logic                o_busy,
   output logic                o_overrun
);
   localparam int unsigned CH_W  = $clog2(N_CH);
   localparam int unsigned RUN_W = $clog2(DEGLITCH_LEN + 1);
   localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`ifdef DMTD_REF_PERIOD_EN
   localparam logic [CH_W-1:0] FIRST_CH = '0;
`else
   localparam logic [CH_W-1:0] FIRST_CH = CH_W'(1);
`endif

   typedef enum logic [1:0] {StIdle, StWaitRef, StCollect, StDrain} state_e;

   logic [N_CH-1:0]  r_sync1, r_sync2, r_beat, r_rise;
   logic [RUN_W-1:0] r_run [N_CH];
   logic [CNT_W-1:0] r_tag, r_tag_ref;
   logic [CNT_W-1:0] r_tag_k [1:N_CH-1];
   logic [N_CH-1:1]  r_cap;
   logic [DLY_W-1:0] r_delay;
   logic             r_delay_sign;
   logic [TMR_W-1:0] r_timer;
   logic [CH_W-1:0]  r_drain_ch;
   logic             r_overrun;
   state_e           r_state, w_state_nxt;

   logic             w_ref_latch, w_valid, w_accept, w_last, w_sel_cap, w_miss;
   logic [N_CH-1:1]  w_cap_nxt;
   logic [CNT_W-1:0] w_sel_tag, w_dly_ext, w_offset, w_phase;

   // Front end: 2-FF sync, then a level change is accepted after DEGLITCH_LEN differing samples.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_beat  <= '0;
         r_rise  <= '0;
         for (int unsigned k = 0; k < N_CH; k++) r_run[k] <= '0;
      end else begin
         r_sync1 <= i_async_clk;
         r_sync2 <= r_sync1;
         r_rise  <= '0;
         for (int unsigned k = 0; k < N_CH; k++) begin
            if (r_sync2[k] == r_beat[k]) begin
               r_run[k] <= '0;
            end else if (r_run[k] == RUN_W'(DEGLITCH_LEN - 1)) begin
               r_beat[k] <= r_sync2[k];
               r_rise[k] <= r_sync2[k];
               r_run[k]  <= '0;
            end else begin
               r_run[k] <= r_run[k] + RUN_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= StIdle;
      else     r_state <= w_state_nxt;
   end

   assign w_valid  = (r_state == StDrain);
   assign w_accept = w_valid & o_stream.ready;
   assign w_last   = (r_drain_ch == CH_W'(N_CH - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_ref_latch = 1'b0;
      w_cap_nxt   = r_cap;
      for (int unsigned k = 1; k < N_CH; k++) begin
         if (r_state == StCollect && r_rise[k]) w_cap_nxt[k] = 1'b1;
      end
      case (r_state)
         StIdle: if (i_en) w_state_nxt = StWaitRef;
         StWaitRef: begin
            if (!i_en) begin
               w_state_nxt = StIdle;
            end else if (r_rise[0]) begin
               w_ref_latch = 1'b1;
               w_state_nxt = StCollect;
            end
         end
         StCollect: begin
            if (!i_en) w_state_nxt = StIdle;
            else if ((&w_cap_nxt) || r_timer == TMR_W'(TIMEOUT - 1)) w_state_nxt = StDrain;
         end
         StDrain: if (w_accept && w_last) w_state_nxt = i_en ? StWaitRef : StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag        <= '0;
         r_tag_ref    <= '0;
         r_delay      <= '0;
         r_delay_sign <= 1'b0;
         r_timer      <= '0;
         r_cap        <= '0;
         r_drain_ch   <= '0;
         r_overrun    <= 1'b0;
         for (int unsigned k = 1; k < N_CH; k++) r_tag_k[k] <= '0;
      end else begin
         r_tag     <= r_tag + CNT_W'(1);
         r_overrun <= r_rise[0] && (r_state == StCollect || r_state == StDrain);
         if (w_ref_latch) begin
            r_tag_ref    <= r_tag;
            r_delay      <= i_delay;
            r_delay_sign <= i_delay_sign;
            r_timer      <= '0;
            r_cap        <= '0;
         end else begin
            if (r_state == StCollect) r_timer <= r_timer + TMR_W'(1);
            r_cap <= w_cap_nxt;
         end
         for (int unsigned k = 1; k < N_CH; k++) begin
            if (r_state == StCollect && r_rise[k] && !r_cap[k]) r_tag_k[k] <= r_tag;
         end
         if (r_state != StDrain && w_state_nxt == StDrain) r_drain_ch <= FIRST_CH;
         else if (w_accept) r_drain_ch <= w_last ? '0 : r_drain_ch + CH_W'(1);
      end
   end

`ifdef DMTD_REF_PERIOD_EN
   logic [CNT_W-1:0] r_prev_ref;
   logic             r_have_ref, r_prev_ok;

   // Period history restarts whenever the meter passes through IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev_ref <= '0;
         r_have_ref <= 1'b0;
         r_prev_ok  <= 1'b0;
      end else if (r_state == StIdle) begin
         r_have_ref <= 1'b0;
      end else if (w_ref_latch) begin
         r_prev_ref <= r_tag_ref;
         r_prev_ok  <= r_have_ref;
         r_have_ref <= 1'b1;
      end
   end
`endif

   assign w_dly_ext = CNT_W'(r_delay);
   assign w_offset  = r_delay_sign ? -w_dly_ext : w_dly_ext;

   always_comb begin
      w_sel_tag = '0;
      w_sel_cap = 1'b0;
      for (int unsigned k = 1; k < N_CH; k++) begin
         if (r_drain_ch == CH_W'(k)) begin
            w_sel_tag = r_tag_k[k];
            w_sel_cap = r_cap[k];
         end
      end
      w_phase = w_sel_tag - r_tag_ref + w_offset;
      w_miss  = !w_sel_cap;
`ifdef DMTD_REF_PERIOD_EN
      if (r_drain_ch == '0) begin
         w_phase = r_tag_ref - r_prev_ref;
         w_miss  = !r_prev_ok;
      end
`endif
      if (w_miss) w_phase = '0;
   end

   assign o_stream.valid = w_valid;
   assign o_stream.ch    = w_valid ? r_drain_ch : '0;
   assign o_stream.phase = w_valid ? w_phase : '0;
   assign o_stream.miss  = w_valid & w_miss;
   assign o_beat_out     = r_beat;
   assign o_busy         = (r_state == StCollect) || (r_state == StDrain);
   assign o_overrun      = r_overrun;
endmodule

// File: tb/tb_dmtd_multi_phase_meter.sv
// Bench for dmtd_multi_phase_meter: drives beat edges at chosen cycles and predicts the stream
// from the drive-time differences (all channels share one front-end latency).
`timescale 1ns/1ps
module tb_dmtd_multi_phase_meter;
   localparam int unsigned N_CH    = 3;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned DLY_W   = 7;
   localparam int unsigned TIMEOUT = 1000;
   localparam int          GLITCH  = -2;

   typedef struct {
      int ch;
      int phase;
      int miss;
   } ent_t;

   logic             clk = 1'b0;
   logic             rst, en, delay_sign;
   logic [N_CH-1:0]  async_clk, beat_out;
   logic [DLY_W-1:0] delay;
   logic             busy, overrun;
   bit               hold_ready, prev_ok;
   int               n_vec, n_err, prev_t0, ovr_cnt, b1_hi;
   int unsigned      cyc;
   ent_t             rx[$];

   dmtd_stream_if #(.CH_W(2), .CNT_W(CNT_W)) s_if ();

   dmtd_multi_phase_meter #(
      .N_CH(N_CH), .CNT_W(CNT_W), .DLY_W(DLY_W), .DEGLITCH_LEN(4), .TIMEOUT(TIMEOUT)
   ) u_dut (
      .clk(clk), .rst(rst), .i_en(en), .i_async_clk(async_clk), .i_delay_sign(delay_sign),
      .i_delay(delay), .o_stream(s_if), .o_beat_out(beat_out), .o_busy(busy),
      .o_overrun(overrun)
   );

   always #5 clk = ~clk;

   // Mirrors the DUT tag counter: cycles since reset release.
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (s_if.valid && s_if.ready)
            rx.push_back('{int'(s_if.ch), int'(s_if.phase), int'(s_if.miss)});
         if (overrun) ovr_cnt <= ovr_cnt + 1;
         if (beat_out[1]) b1_hi <= b1_hi + 1;
      end
   end

   initial begin
      s_if.ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 s_if.ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input longint got, input longint exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, s_if.valid, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_overrun"}, overrun, 0);
      chk({tag, "_beat"}, beat_out, 0);
      chk({tag, "_ch"}, s_if.ch, 0);
      chk({tag, "_phase"}, s_if.phase, 0);
      chk({tag, "_miss"}, s_if.miss, 0);
   endtask

   // d<0: no edge; GLITCH on ch1: a 3-cycle pulse. Edges are cycles after the ch0 rise.
   task automatic run_meas(input string name, input int d1, input int d2, input bit sgn,
                           input int dly, input bit bp);
      int   ds[3];
      int   t0, base, ovr0, hi0, off, last, n_exp;
      int   s_ch, s_ph, s_ms;
      bit   ok;
      ent_t exp_q[$];
      ds = '{0, d1, d2};
      delay_sign = sgn;
      delay      = DLY_W'(dly);
      hold_ready = bp;
      base = rx.size();
      ovr0 = ovr_cnt;
      hi0  = b1_hi;
      @(posedge clk);
      #1;
      t0   = int'(cyc);
      last = 24;
      for (int k = 0; k < 3; k++) if (ds[k] > last) last = ds[k];
      for (int c = 0; c <= last; c++) begin
         for (int k = 0; k < 3; k++) if (ds[k] == c) async_clk[k] = 1'b1;
         if (d1 == GLITCH) async_clk[1] = (c >= 20 && c < 23);
         tick(1);
      end

      off = sgn ? -dly : dly;
`ifdef DMTD_REF_PERIOD_EN
      exp_q.push_back('{0, prev_ok ? ((t0 - prev_t0) & 'hFFFF) : 0, prev_ok ? 0 : 1});
`endif
      prev_t0 = t0;
      prev_ok = 1'b1;
      for (int k = 1; k < 3; k++) begin
         if (ds[k] >= 1 && ds[k] < int'(TIMEOUT)) exp_q.push_back('{k, (ds[k] + off) & 'hFFFF, 0});
         else exp_q.push_back('{k, 0, 1});
      end
      n_exp = exp_q.size();

      if (bp) begin
         ok = 1'b0;
         for (int i = 0; i < 3000 && !ok; i++) begin
            if (s_if.valid) ok = 1'b1;
            else tick(1);
         end
         chk({name, "_bp_reach"}, ok, 1);
         s_ch = int'(s_if.ch);
         s_ph = int'(s_if.phase);
         s_ms = int'(s_if.miss);
         for (int i = 0; i < 20; i++) begin
            if (i == 0) async_clk[0] = 1'b0;
            if (i == 8) async_clk[0] = 1'b1;
            tick(1);
            chk({name, "_bp_valid"}, s_if.valid, 1);
            chk({name, "_bp_ch"}, s_if.ch, s_ch);
            chk({name, "_bp_phase"}, s_if.phase, s_ph);
            chk({name, "_bp_miss"}, s_if.miss, s_ms);
         end
         hold_ready = 1'b0;
      end

      for (int i = 0; i < 3000 && rx.size() < base + n_exp; i++) tick(1);
      for (int i = 0; i < 3000 && busy; i++) tick(1);
      tick(20);
      chk({name, "_count"}, rx.size() - base, n_exp);
      for (int i = 0; i < n_exp && base + i < rx.size(); i++) begin
         chk({name, "_ch"}, rx[base + i].ch, exp_q[i].ch);
         chk({name, "_phase"}, rx[base + i].phase, exp_q[i].phase);
         chk({name, "_miss"}, rx[base + i].miss, exp_q[i].miss);
      end
      chk({name, "_overruns"}, ovr_cnt - ovr0, bp ? 1 : 0);
      chk({name, "_busy_end"}, busy, 0);
      if (d1 == GLITCH) chk({name, "_beat1_rose"}, b1_hi - hi0, 0);
      async_clk = '0;
      tick(12);
   endtask

   initial begin
      int base, d1, d2;
      rst = 1'b1; en = 1'b0; async_clk = '0; delay_sign = 1'b0; delay = '0;
      hold_ready = 1'b0; prev_ok = 1'b0; prev_t0 = 0;
      tick(4);
      chk_zero("reset");
      rst = 1'b0;
      en  = 1'b1;
      tick(12);

      run_meas("basic", 50, 130, 1'b0, 0, 1'b0);
      run_meas("offset", 50, 130, 1'b1, 10, 1'b0);
      run_meas("same_cycle", 0, 40, 1'b0, 5, 1'b0);
      run_meas("glitch", GLITCH, 60, 1'b0, 0, 1'b0);
      run_meas("backpressure", 5, 9, 1'b0, 3, 1'b1);
      for (int t = 0; t < 6; t++) begin
         d1 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 900));
         d2 = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(1, 900));
         run_meas("rand", d1, d2, 1'($urandom_range(0, 1)), int'($urandom_range(0, 127)),
                  $urandom_range(0, 2) == 0);
      end

      // en=0 during COLLECT discards the measurement.
      base = rx.size();
      async_clk[0] = 1'b1;
      for (int i = 0; i < 100 && !busy; i++) tick(1);
      chk("abort_busy", busy, 1);
      tick(30);
      en = 1'b0;
      tick(3);
      chk("abort_idle", busy, 0);
      async_clk = '0;
      tick(40);
      chk("abort_no_result", rx.size() - base, 0);
      en = 1'b1;
      prev_ok = 1'b0;
      tick(5);

      // Reset during COLLECT.
      async_clk[0] = 1'b1;
      for (int i = 0; i < 100 && !busy; i++) tick(1);
      chk("rst_busy", busy, 1);
      tick(20);
      rst = 1'b1;
      tick(1);
      chk_zero("rst_mid");
      async_clk = '0;
      tick(3);
      rst = 1'b0;
      prev_ok = 1'b0;
      tick(12);

      // Reference tag lands near 65530 so the measurement straddles the counter wrap.
      while (cyc < 65523) tick(1);
      run_meas("wrap", 10, 20, 1'b1, 10, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/dmtd_multi_phase_meter.md
Name: dmtd_multi_phase_meter

Overview:
- Multi-channel digital dual-mixer time-difference phase meter.
- Channel 0 is the reference beat. Channels 1..N_CH-1 are measured against it.
- Each async beat input is synchronised and deglitched, then its rising edges are time-tagged on a free-running counter.
- Per-channel phase differences, with a signed programmable offset applied, leave on a valid/ready stream. The block sits behind the top-level pin wrapper.

Parameters:
- N_CH, 3, channel count including reference; minimum 2.
- CNT_W, 16, tag counter and phase result width.
- DLY_W, 7, offset magnitude width.
- DEGLITCH_LEN, 4, consecutive equal samples required to accept a beat level change; minimum 1.
- TIMEOUT, 1000, cycles after a reference edge before missing channels are reported.

Ports:
- clk  in  1  sampling (offset) clock
- rst  in  1  synchronous active-high reset
- en  in  1  measurement enable
- async_clk  in  N_CH  async beat inputs; bit 0 = reference
- delay_sign  in  1  0 = add delay, 1 = subtract
- delay  in  DLY_W  offset magnitude, sampled at the reference edge
- out_valid  out  1  result valid
- out_ready  in  1  consumer accept
- out_ch  out  max(1,clog2(N_CH))  channel index of result
- out_phase  out  CNT_W  phase result
- out_miss  out  1  channel had no edge before timeout
- beat_out  out  N_CH  deglitched beat levels
- busy  out  1  high in COLLECT or DRAIN
- overrun  out  1  one-cycle pulse per ignored reference edge

Behaviour:
- Reset, synchronous on rst=1, sets every output to 0 and tag counter to 0. FSM goes to IDLE and all captures are cleared. Reset overrides everything, including mid-COLLECT and mid-DRAIN.
- Front end, per channel:
  - 2-FF synchroniser, then deglitcher.
  - Deglitched level changes only after the synchronised value differs from it for DEGLITCH_LEN consecutive cycles. Any shorter excursion resets the run count.
  - Rising edge event is a 1-cycle pulse. Total latency from a stable input transition is 2+DEGLITCH_LEN cycles, identical for all channels.
- Tag counter: free-running CNT_W bits from reset, +1 per cycle, wraps silently.
- FSM states:
  - IDLE: en=0. Leave for WAIT_REF when en=1.
  - WAIT_REF: on a ch0 edge, latch tag_ref, delay and delay_sign; clear captures; start the timeout counter at 0; go to COLLECT. If en=0, go to IDLE.
  - COLLECT:
    - For channel k≥1, the first edge strictly after the reference-edge cycle latches tag_k. Later edges of k are ignored.
    - Go to DRAIN when all channels are captured or the timeout counter reaches TIMEOUT-1.
    - en=0 aborts to IDLE and discards the measurement.
  - DRAIN:
    - Presents channels 1..N_CH-1 in ascending order.
    - out_valid=1 with out_ch/out_phase/out_miss held stable until the cycle out_ready=1. The next channel is presented in the following cycle, no bubble required.
    - After the last accept, go to WAIT_REF if en=1, else IDLE. en=0 does not abort DRAIN.
- Phase arithmetic: phase_k = (tag_k − tag_ref + (delay_sign ? −delay : +delay)) mod 2^CNT_W, with delay zero-extended.
- Missing channel: out_miss=1, out_phase=0.
- ch0 edges in COLLECT or DRAIN are not measured; each pulses overrun for 1 cycle.
- A channel edge in the same cycle as the reference edge is not captured for that measurement.
- busy = (state is COLLECT or DRAIN).
- beat_out gives the deglitched levels directly.

Optional Feature:
- DMTD_REF_PERIOD_EN.
- When defined, DRAIN first presents an entry with out_ch=0 and out_phase = tag_ref − previous tag_ref (mod 2^CNT_W), i.e. the reference beat period.
  - The first measurement after reset or after IDLE reports out_miss=1, phase 0.
  - The delay offset is not applied to this entry.
- When undefined, channel 0 is never emitted and no previous-tag register exists.

Test Plan:
- Use N_CH=3, DEGLITCH_LEN=4, TIMEOUT=1000.
- Basic: en=1, delay=0; ch0 rises at cycle 100, ch1 at 150, ch2 at 230, all held → stream (ch1, 50, miss 0), (ch2, 130, miss 0), then back to WAIT_REF.
- Offset and wrap: delay_sign=1, delay=10, same timing → 40, 120. Ref edge tag 65530, ch1 tag 4 → (4−65530−10) mod 65536 = 0.
- Glitch/timeout: ch1 high for 3 cycles only, ch2 rises 60 cycles after ref → beat_out[1] never rises; ch1 reported miss=1, phase 0 after TIMEOUT cycles; ch2 reported 60.
- Backpressure/overrun: hold out_ready=0 for 20 cycles in DRAIN → out_valid stays 1 with data stable. A ch0 edge during that window → one overrun pulse and no new measurement.
- Reset/abort: assert rst mid-COLLECT → next cycle all outputs 0, state IDLE. Separately, en=0 mid-COLLECT → no results are emitted.
- With DMTD_REF_PERIOD_EN: ref edges 500 cycles apart → first drain (ch0, 0, miss 1), second drain (ch0, 500, miss 0) before the ch1 and ch2 entries.
